// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, MEM-stage FSM encoding and
// the forwarding-select codes used by the EX-stage forwarding unit.
package core_pkg;

   localparam int REG_W = 5;
   localparam int XLEN  = 32;

   typedef enum logic [0:0] {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   localparam logic [1:0] FWD_NONE   = 2'b00;
   localparam logic [1:0] FWD_MEM_WB = 2'b01;
   localparam logic [1:0] FWD_EX_MEM = 2'b10;

   function automatic logic word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: issues the request, waits for ack with a
// bounded timeout and reports completion, abort and the upstream stall.
module dmem_access_fsm
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       ack,
   output logic       req,
   output logic       complete,
   output logic       abort,
   output logic       stall,
   output mem_state_t dbg_state
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The request is held in WAIT by the frozen EX/MEM register, so the
   // address/data seen by memory stay stable without extra storage here.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req      = 1'b0;
      complete = 1'b0;
      abort    = 1'b0;
      stall    = 1'b0;
      unique case (state_q)
         MEM_IDLE: begin
            if (start) begin
               req = 1'b1;
               if (ack) begin
                  complete = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = MEM_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         MEM_WAIT: begin
            req = 1'b1;
            if (ack) begin
               complete = 1'b1;
               state_d  = MEM_IDLE;
               cnt_d    = '0;
            end else if (cnt_q == TIMEOUT_CNT) begin
               abort   = 1'b1;
               state_d = MEM_IDLE;
               cnt_d   = '0;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = MEM_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: EX/MEM and MEM/WB registers, the data-memory
// access and the forwarding sources consumed by the EX forwarding unit.
module mem_wb_stage
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_alu_z,
   input  logic [XLEN-1:0]  ex_rt_data,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_mem_write,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   input  logic [XLEN-1:0]  dmem_rdata,
   input  logic             dmem_ack,
   output logic             stall,
   output logic             load_pending,
   output logic             bus_error,
   output logic [REG_W-1:0] EX_MEM_Rd,
   output logic [XLEN-1:0]  EX_MEM_RdData,
   output logic             EX_MEM_RegWrite,
   output logic [REG_W-1:0] MEM_WB_Rd,
   output logic [XLEN-1:0]  MEM_WB_RdData,
   output logic             MEM_WB_RegWrite,
   output logic             wb_we,
   output logic [REG_W-1:0] wb_addr,
   output logic [XLEN-1:0]  wb_data
);

   // EX/MEM register
   logic             exm_valid;
   logic [XLEN-1:0]  exm_alu_z;
   logic [XLEN-1:0]  exm_rt_data;
   logic [REG_W-1:0] exm_rd;
   logic             exm_reg_write;
   logic             exm_mem_read;
   logic             exm_mem_write;

   // MEM/WB register
   logic             mwb_valid;
   logic             mwb_reg_write;
   logic [REG_W-1:0] mwb_rd;
   logic [XLEN-1:0]  mwb_data;

   logic       mem_op, is_store, is_load, misaligned, aligned_op;
   logic       fsm_req, fsm_complete, fsm_abort, fsm_stall;
   logic       retire;
   mem_state_t fsm_state;

   // A read+write combination is resolved as a store.
   assign is_store   = exm_mem_write;
   assign is_load    = exm_mem_read & ~exm_mem_write;
   assign mem_op     = exm_valid & (exm_mem_read | exm_mem_write);
   assign misaligned = mem_op & ~word_aligned(exm_alu_z);
   assign aligned_op = mem_op & ~misaligned;

   dmem_access_fsm #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .start     (aligned_op),
      .ack       (dmem_ack),
      .req       (fsm_req),
      .complete  (fsm_complete),
      .abort     (fsm_abort),
      .stall     (fsm_stall),
      .dbg_state (fsm_state)
   );

   assign retire = ~fsm_stall & ~fsm_abort & ~misaligned;

   always_ff @(posedge clk) begin
      if (reset) begin
         exm_valid     <= 1'b0;
         exm_alu_z     <= '0;
         exm_rt_data   <= '0;
         exm_rd        <= '0;
         exm_reg_write <= 1'b0;
         exm_mem_read  <= 1'b0;
         exm_mem_write <= 1'b0;
      end else if (!fsm_stall) begin
         exm_valid     <= ex_valid;
         exm_alu_z     <= ex_alu_z;
         exm_rt_data   <= ex_rt_data;
         exm_rd        <= ex_rd;
         exm_reg_write <= ex_reg_write;
         exm_mem_read  <= ex_mem_read;
         exm_mem_write <= ex_mem_write;
      end
   end

   // A retiring aligned load has necessarily completed this cycle, so
   // dmem_rdata is valid whenever it is selected.
   always_ff @(posedge clk) begin
      if (reset) begin
         mwb_valid     <= 1'b0;
         mwb_reg_write <= 1'b0;
         mwb_rd        <= '0;
         mwb_data      <= '0;
      end else if (retire) begin
         mwb_valid     <= exm_valid;
         mwb_reg_write <= exm_reg_write & ~is_store;
         mwb_rd        <= exm_rd;
         mwb_data      <= is_load ? dmem_rdata : exm_alu_z;
      end else begin
         mwb_valid     <= 1'b0;
      end
   end

   // While waiting, EX/MEM is frozen by the stall and must hold the access.
   always_ff @(posedge clk) begin
      if (!reset && fsm_state == MEM_WAIT) begin
         assert (aligned_op)
            else $error("mem_wb_stage: WAIT without a held aligned access");
      end
   end

   assign dmem_req     = fsm_req;
   assign dmem_we      = fsm_req & is_store;
   assign dmem_addr    = fsm_req ? exm_alu_z   : '0;
   assign dmem_wdata   = (fsm_req & is_store) ? exm_rt_data : '0;

   assign stall        = fsm_stall;
   assign load_pending = exm_valid & is_load;
   assign bus_error    = misaligned | fsm_abort;

   assign EX_MEM_Rd       = exm_rd;
   assign EX_MEM_RdData   = exm_alu_z;
   assign EX_MEM_RegWrite = exm_valid & exm_reg_write & (exm_rd != '0)
                            & ~exm_mem_read & ~exm_mem_write;

   assign MEM_WB_Rd       = mwb_rd;
   assign MEM_WB_RdData   = mwb_data;
   assign MEM_WB_RegWrite = mwb_valid & mwb_reg_write & (mwb_rd != '0);

   assign wb_we   = MEM_WB_RegWrite;
   assign wb_addr = MEM_WB_Rd;
   assign wb_data = MEM_WB_RdData;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by
// random instructions checked against an instruction-level expectation model.
module tb_mem_wb_stage;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [31:0] ex_alu_z;
   logic [31:0] ex_rt_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall;
   logic        load_pending;
   logic        bus_error;
   logic [4:0]  EX_MEM_Rd;
   logic [31:0] EX_MEM_RdData;
   logic        EX_MEM_RegWrite;
   logic [4:0]  MEM_WB_Rd;
   logic [31:0] MEM_WB_RdData;
   logic        MEM_WB_RegWrite;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_tests = 0;
   int n_fail  = 0;

   mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .ex_valid        (ex_valid),
      .ex_alu_z        (ex_alu_z),
      .ex_rt_data      (ex_rt_data),
      .ex_rd           (ex_rd),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_read     (ex_mem_read),
      .ex_mem_write    (ex_mem_write),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_rdata      (dmem_rdata),
      .dmem_ack        (dmem_ack),
      .stall           (stall),
      .load_pending    (load_pending),
      .bus_error       (bus_error),
      .EX_MEM_Rd       (EX_MEM_Rd),
      .EX_MEM_RdData   (EX_MEM_RdData),
      .EX_MEM_RegWrite (EX_MEM_RegWrite),
      .MEM_WB_Rd       (MEM_WB_Rd),
      .MEM_WB_RdData   (MEM_WB_RdData),
      .MEM_WB_RegWrite (MEM_WB_RegWrite),
      .wb_we           (wb_we),
      .wb_addr         (wb_addr),
      .wb_data         (wb_data)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      ex_valid     = 1'b0;
      ex_alu_z     = $urandom;
      ex_rt_data   = $urandom;
      ex_rd        = 5'($urandom_range(0, 31));
      ex_reg_write = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_mem_write = 1'($urandom_range(0, 1));
   endtask

   // One instruction through MEM and WB. lat = cycles until memory acks
   // (values above TIMEOUT mean it never acks).
   task automatic do_instr(input logic rw, input logic mr, input logic mw,
                           input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] rtd, input int lat,
                           input logic [31:0] rdata);
      logic mem_op, st, ld, mis, aligned, abort_exp, exp_we;
      int   nstall;
      mem_op    = mr | mw;
      st        = mw;
      ld        = mr & ~mw;
      mis       = mem_op && (addr[1:0] != 2'b00);
      aligned   = mem_op && !mis;
      abort_exp = aligned && (lat > TIMEOUT);
      nstall    = !aligned ? 0 : (lat > TIMEOUT ? TIMEOUT : lat);

      @(negedge clk);
      ex_valid = 1'b1; ex_alu_z = addr; ex_rt_data = rtd; ex_rd = rd;
      ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
      dmem_ack = 1'b0;
      @(posedge clk);
      for (int c = 0; c <= nstall; c++) begin
         @(negedge clk);
         if (c == 0) idle_inputs();
         dmem_ack   = aligned ? 1'(c == lat) : 1'($urandom_range(0, 1));
         dmem_rdata = (aligned && c == lat) ? rdata : $urandom;
         #1;
         chk("stall", 32'(stall), 32'(c < nstall));
         chk("dmem_req", 32'(dmem_req), 32'(aligned));
         if (aligned) begin
            chk("dmem_addr", dmem_addr, addr);
            chk("dmem_we", 32'(dmem_we), 32'(st));
            if (st) chk("dmem_wdata", dmem_wdata, rtd);
         end
         chk("bus_error", 32'(bus_error), 32'(mis || (abort_exp && c == TIMEOUT)));
         chk("load_pending", 32'(load_pending), 32'(ld));
         chk("exm_regwrite", 32'(EX_MEM_RegWrite), 32'(rw && rd != 0 && !mem_op));
         chk("exm_rd", 32'(EX_MEM_Rd), 32'(rd));
         chk("exm_rddata", EX_MEM_RdData, addr);
         chk("wb_we_in_mem", 32'(wb_we), 32'h0);
         @(posedge clk);
      end
      @(negedge clk);
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #1;
      exp_we = rw && rd != 0 && !st && !mis && !abort_exp;
      chk("wb_we", 32'(wb_we), 32'(exp_we));
      chk("mwb_regwrite", 32'(MEM_WB_RegWrite), 32'(exp_we));
      if (exp_we) begin
         chk("wb_addr", 32'(wb_addr), 32'(rd));
         chk("wb_data", wb_data, ld ? rdata : addr);
      end
      chk("req_after", 32'(dmem_req), 32'h0);
      chk("stall_after", 32'(stall), 32'h0);
      chk("berr_after", 32'(bus_error), 32'h0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"}, 32'(dmem_req), 32'h0);
      chk({tag, "_stall"}, 32'(stall), 32'h0);
      chk({tag, "_berr"}, 32'(bus_error), 32'h0);
      chk({tag, "_ldp"}, 32'(load_pending), 32'h0);
      chk({tag, "_exm_rd"}, 32'(EX_MEM_Rd), 32'h0);
      chk({tag, "_exm_data"}, EX_MEM_RdData, 32'h0);
      chk({tag, "_exm_rw"}, 32'(EX_MEM_RegWrite), 32'h0);
      chk({tag, "_mwb_rd"}, 32'(MEM_WB_Rd), 32'h0);
      chk({tag, "_mwb_data"}, MEM_WB_RdData, 32'h0);
      chk({tag, "_wb_we"}, 32'(wb_we), 32'h0);
   endtask

   initial begin
      logic        rw, mr, mw;
      logic [4:0]  rd;
      logic [31:0] addr;
      int          kind, lat;

      reset = 1'b1;
      idle_inputs();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all_zero("reset");

      // directed scenarios
      do_instr(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0);
      do_instr(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
      do_instr(1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0200, 32'h0000_CAFE, 0, 32'h0);
      do_instr(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0300, 32'h0, 100, 32'h0);
      do_instr(1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0777, 32'h0, 0, 32'h0);
      do_instr(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0102, 32'h0, 0, 32'h1111_1111);
      do_instr(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_5555, 32'h0, 0, 32'h0);
      do_instr(1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_0400, 32'h0, TIMEOUT, 32'h1357_9BDF);
      do_instr(1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_0404, 32'h0, TIMEOUT + 1, 32'h0);
      do_instr(1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_0500, 32'h0000_ABCD, 2, 32'h2222_2222);
      do_instr(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0600, 32'h0, 1, 32'h3333_3333);

      // random instructions
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 3);
         rw   = 1'($urandom_range(0, 3) != 0);
         mr   = (kind == 1 || kind == 3);
         mw   = (kind == 2 || kind == 3);
         rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         addr = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         lat  = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 4)
                                            : $urandom_range(0, 4);
         do_instr(rw, mr, mw, rd, addr, $urandom, lat, $urandom);
      end

      // reset in the middle of a load's wait
      @(negedge clk);
      ex_valid = 1'b1; ex_alu_z = 32'h0000_0800; ex_rd = 5'd10;
      ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      dmem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("mid_req", 32'(dmem_req), 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset      = 1'b0;
      #1;
      check_all_zero("midrst");
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      @(posedge clk);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      chk("late_ack_wb_we", 32'(wb_we), 32'h0);
      chk("late_ack_req", 32'(dmem_req), 32'h0);

      // pipeline still works after the aborted access
      do_instr(1'b1, 1'b0, 1'b0, 5'd11, 32'h0000_9999, 32'h0, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline MEM and WB stages of the 5-stage MIPS core. Accepts EX results into the EX/MEM register and performs the data-memory access over a variable-latency req/ack port.
- Retires results through the MEM/WB register into the register-file write port.
- It is the producing end of the forwarding interface: it drives the EX_MEM_* and MEM_WB_* Rd/RdData/RegWrite signals the EX-stage forwarding unit consumes. It also drives the stall that freezes upstream stages.

Parameters:
- TIMEOUT, 16, max cycles dmem_req may wait for dmem_ack before the access is aborted with a bus error.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage presents an instruction this cycle
- ex_alu_z  in  32  ALU result (address for loads/stores)
- ex_rt_data  in  32  forwarded Rt value (store data)
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes Rd
- ex_mem_read  in  1  load word
- ex_mem_write  in  1  store word
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word address (byte address, bits [1:0] = 0)
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- stall  out  1  hold IF/ID/EX and do not load EX/MEM
- load_pending  out  1  EX/MEM holds a valid load (for the load-use hazard unit)
- bus_error  out  1  one-cycle pulse: misaligned or timed-out access
- EX_MEM_Rd  out  5  forwarding source, MEM stage
- EX_MEM_RdData  out  32  EX/MEM ALU result
- EX_MEM_RegWrite  out  1  valid & reg_write & Rd!=0 & not a load
- MEM_WB_Rd  out  5  forwarding source, WB stage
- MEM_WB_RdData  out  32  write-back value
- MEM_WB_RegWrite  out  1  valid & reg_write & Rd!=0
- wb_we  out  1  register-file write enable (equals MEM_WB_RegWrite)
- wb_addr  out  5  equals MEM_WB_Rd
- wb_data  out  32  equals MEM_WB_RdData

Behaviour:
- Reset (synchronous) clears:
  - EX/MEM valid and MEM/WB valid.
  - All Rd/RdData fields to 0.
  - State to IDLE and the counter to 0.
  - Consequence: every output is 0 in the cycle after the reset edge. Reset mid-access abandons the access; dmem_req drops with no write-back.
- EX/MEM load: on each edge with stall=0, load ex_* fields and valid = ex_valid. With stall=1, hold.
- mem_op = EX/MEM valid & (mem_read | mem_write). mem_read and mem_write are never both 1; if they are, treat the instruction as a store.
- Misaligned: mem_op with alu_z[1:0] != 0.
  - No dmem_req is issued; bus_error pulses this cycle.
  - The instruction is killed: a bubble goes to MEM/WB. No stall.
- FSM states:
  - IDLE
    - An aligned mem_op drives dmem_req=1, with addr/we/wdata taken from EX/MEM.
    - If dmem_ack is high the same cycle, the access completes with zero wait.
    - Otherwise go to WAIT with counter=1.
  - WAIT
    - dmem_req stays 1 and addr/we/wdata stay stable.
    - dmem_ack completes the access and returns to IDLE.
    - If instead counter == TIMEOUT, abort: bus_error pulses, a bubble goes to MEM/WB, return to IDLE.
    - Otherwise the counter increments.
- stall = aligned mem_op & no completion & no abort this cycle. An access of N wait cycles stalls exactly N cycles.
- MEM/WB update, every edge:
  - If stall, or the access was aborted or misaligned: MEM_WB valid <= 0 (bubble).
  - Otherwise copy EX/MEM. RdData = dmem_rdata for loads, alu_z for all else.
- Stores never set RegWrite. Rd==0 never produces RegWrite, on both forwarding outputs and wb_we.
- Load data is not forwardable from EX/MEM: EX_MEM_RegWrite=0 while load_pending=1.
- dmem_ack while dmem_req=0 is ignored.

Decomposition:
- Shared package core_pkg:
  - REG_W=5, XLEN=32.
  - FSM state encoding (MEM_IDLE, MEM_WAIT).
  - Forwarding-select constants FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, reused by the EX forwarding unit.
- One natural sub-module: dmem_access_fsm, holding the IDLE/WAIT state, the timeout counter, request holding and the completion/abort/stall outputs.
- The pipeline registers stay in the top module.

Test Plan:
- ALU op: ex_valid=1, alu_z=0x0000_1234, rd=5, reg_write=1.
  - Next cycle EX_MEM_RegWrite=1, EX_MEM_RdData=0x1234.
  - One cycle later wb_we=1, wb_addr=5, wb_data=0x1234. stall never asserted.
- Load with 3-cycle ack latency: addr 0x100, rd=8, dmem_rdata=0xDEADBEEF.
  - stall=1 for 3 cycles; load_pending=1 and EX_MEM_RegWrite=0 throughout.
  - MEM_WB is a bubble during the stall.
  - Then wb_we=1, wb_addr=8, wb_data=0xDEADBEEF.
- Store with zero-wait ack: addr 0x200, rt_data=0xCAFE.
  - dmem_req=1, dmem_we=1, wdata=0xCAFE in one cycle; no stall; wb_we stays 0.
- Timeout with TIMEOUT=16: load that is never acked.
  - stall=1 for 16 cycles, then bus_error pulses 1 cycle.
  - dmem_req drops, no write-back, the next instruction proceeds.
- Misaligned load at 0x102 → no dmem_req, bus_error=1 that cycle, no write-back. Also: rd=0 ALU op → wb_we=0 and EX_MEM_RegWrite=0.
- Reset asserted during WAIT of a load → the cycle after the reset edge, dmem_req=0, stall=0 and all forwarding outputs are 0. A late dmem_ack afterwards has no effect.
